// File: rtl/amo_seq_ctl_pkg.sv
// Shared core definitions for AMO handling: funct5 codes, opcode,
// sequencer state encoding and the funct5 -> micro-op count helper.
package amo_seq_ctl_pkg;

    // Major opcode of the A-extension instructions
    localparam logic [6:0] OPC_AMO = 7'b0101111;

    // funct5 codes (ir[31:27]) of the AMOs this core expands
    localparam logic [4:0] AMOSWAP = 5'b00001;
    localparam logic [4:0] AMOADD  = 5'b00000;
    localparam logic [4:0] AMOXOR  = 5'b00100;
    localparam logic [4:0] AMOAND  = 5'b01100;
    localparam logic [4:0] AMOOR   = 5'b01000;

    // Sequencer state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOCK  = 3'd1;
    localparam logic [2:0] S_LD    = 3'd2;
    localparam logic [2:0] S_OP    = 3'd3;
    localparam logic [2:0] S_ST    = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_LOCK  = S_LOCK,
        ST_LD    = S_LD,
        ST_OP    = S_OP,
        ST_ST    = S_ST,
        ST_DRAIN = S_DRAIN
    } amo_state_e;

    // Number of micro-op steps for a funct5: swap needs no ALU step,
    // the logic/add ops need LD+OP+ST, anything else is not expanded (0).
    function automatic logic [1:0] amo_len(input logic [4:0] funct5);
        logic [1:0] len;
        len = 2'd0;
        case (funct5)
            AMOSWAP:                         len = 2'd2;
            AMOADD, AMOXOR, AMOAND, AMOOR:   len = 2'd3;
            default:                         len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/amo_seq_ctl.sv
// AMO micro-op handshake responder. Acks the pre-decoder's LD/OP/ST
// steps, holds the data-bus lock across the whole read-modify-write and
// releases it once the store has retired (or the drain wait times out).
module amo_seq_ctl #(
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       amo_req,
    input  logic [4:0] amo_funct5,
    input  logic       stall,
    input  logic       flush,
    output logic       lock_req,
    input  logic       lock_gnt,
    input  logic       st_done,
    output logic       amo_ack,
    output logic       busy,
    output logic       amo_err
);
    import amo_seq_ctl_pkg::*;

    localparam logic [CW-1:0] TCNT_LAST = CW'(TIMEOUT - 1);

    amo_state_e    state_reg, state_next;
    logic [1:0]    len_reg, len_next;
    logic [CW-1:0] tcnt_reg, tcnt_next;
    logic          lock_req_reg;
    logic          amo_err_reg, amo_err_next;
    logic          in_step;
    logic [1:0]    req_len;

    assign req_len = amo_len(amo_funct5);

    // A step is offered to the pre-decoder only while in LD/OP/ST
    assign in_step  = (state_reg == ST_LD) || (state_reg == ST_OP) || (state_reg == ST_ST);
    assign amo_ack  = amo_req && in_step;
    assign busy     = (state_reg != ST_IDLE);
    assign lock_req = lock_req_reg;
    assign amo_err  = amo_err_reg;

    // Next-state, sequence length, drain counter and timeout pulse
    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        tcnt_next    = tcnt_reg;
        amo_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (amo_req && (req_len != 2'd0)) begin
                    state_next = ST_LOCK;
                    len_next   = req_len;
                end
            end
            ST_LOCK: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (lock_gnt) begin
                    state_next = ST_LD;
                end
            end
            ST_LD: begin
                // Pre-decoder reset or flush before the store: nothing written yet
                if (!amo_req || flush) begin
                    state_next = ST_IDLE;
                end else if (!stall) begin
                    state_next = (len_reg == 2'd3) ? ST_OP : ST_ST;
                end
            end
            ST_OP: begin
                if (!amo_req || flush) begin
                    state_next = ST_IDLE;
                end else if (!stall) begin
                    state_next = ST_ST;
                end
            end
            ST_ST: begin
                // An accepted store is already issued, so it wins over flush
                if (!amo_req) begin
                    state_next = ST_IDLE;
                end else if (!stall) begin
                    state_next = ST_DRAIN;
                    tcnt_next  = '0;
                end else if (flush) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (st_done) begin
                    state_next = ST_IDLE;
                    tcnt_next  = '0;
                end else if (tcnt_reg == TCNT_LAST) begin
                    state_next   = ST_IDLE;
                    tcnt_next    = '0;
                    amo_err_next = 1'b1;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, length, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            len_reg      <= 2'd0;
            tcnt_reg     <= '0;
            lock_req_reg <= 1'b0;
            amo_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            tcnt_reg     <= tcnt_next;
            // Lock is wanted for exactly as long as the sequencer is not idle
            lock_req_reg <= (state_next != ST_IDLE);
            amo_err_reg  <= amo_err_next;
        end
    end

endmodule

// File: tb/tb_amo_seq_ctl.sv
// Directed bench for amo_seq_ctl with a step-list reference model and a
// per-cycle output comparison on the falling clock edge.
module tb_amo_seq_ctl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       amo_req = 1'b0;
    logic [4:0] amo_funct5 = 5'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       lock_gnt = 1'b0;
    logic       st_done = 1'b0;
    logic       lock_req, amo_ack, busy, amo_err;

    int vec_cnt = 0;
    int miss_cnt = 0;

    amo_seq_ctl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .amo_req(amo_req), .amo_funct5(amo_funct5),
        .stall(stall), .flush(flush), .lock_req(lock_req), .lock_gnt(lock_gnt),
        .st_done(st_done), .amo_ack(amo_ack), .busy(busy), .amo_err(amo_err)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 waiting for lock, 2 walking the
    // micro-op list, 3 waiting for the store to retire.
    int m_phase = 0;
    int m_nsteps = 0;
    int m_idx = 0;
    int m_wait = 0;
    bit m_err = 1'b0;

    function automatic int ref_len(input logic [4:0] f);
        case (f)
            5'b00001:                               return 2;
            5'b00000, 5'b00100, 5'b01100, 5'b01000: return 3;
            default:                                return 0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_nsteps = 0; m_idx = 0; m_wait = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            case (m_phase)
                0: if (amo_req && ref_len(amo_funct5) != 0) begin
                       m_nsteps = ref_len(amo_funct5); m_idx = 0; m_phase = 1;
                   end
                1: if (flush) m_phase = 0;
                   else if (lock_gnt) m_phase = 2;
                2: begin
                    if (!amo_req) m_phase = 0;
                    else if (!stall && m_idx == m_nsteps - 1) begin
                        m_phase = 3; m_wait = 0;
                    end else if (flush) m_phase = 0;
                    else if (!stall) m_idx = m_idx + 1;
                end
                default: begin
                    if (st_done) m_phase = 0;
                    else if (m_wait == TO - 1) begin m_phase = 0; m_err = 1'b1; end
                    else m_wait = m_wait + 1;
                end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus step counters
    int ack_cycles = 0;
    int accepted = 0;
    always @(negedge clk) begin
        chk("ack",  int'(amo_ack),  int'(m_phase == 2 && amo_req));
        chk("busy", int'(busy),     int'(m_phase != 0));
        chk("lock", int'(lock_req), int'(m_phase != 0));
        chk("err",  int'(amo_err),  int'(m_err));
        if (amo_ack === 1'b1) ack_cycles++;
        if (amo_ack === 1'b1 && !stall) accepted++;
    end

    task automatic cyc(input logic r, input logic [4:0] f, input logic s,
                       input logic fl, input logic g, input logic d);
        amo_req = r; amo_funct5 = f; stall = s; flush = fl; lock_gnt = g; st_done = d;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_err;
        int err_hits;

        // Reset
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_lock", int'(lock_req), 0);
        chk("rst_ack",  int'(amo_ack), 0);
        chk("rst_err",  int'(amo_err), 0);
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        $display("reset released");

        // amoadd: two LOCK cycles, three acked steps, st_done after 4 drain cycles
        ack_cycles = 0; accepted = 0;
        cyc(1, 5'b00000, 0, 0, 0, 0);
        chk("add_lock_up", int'(lock_req), 1);
        cyc(1, 5'b00000, 0, 0, 0, 0);
        cyc(1, 5'b00000, 0, 0, 1, 0);
        cyc(1, 5'b00000, 0, 0, 0, 0);
        cyc(1, 5'b00000, 0, 0, 0, 0);
        cyc(1, 5'b00000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 5'b00000, 0, 0, 0, 0);
        chk("add_lock_held", int'(lock_req), 1);
        cyc(0, 5'b00000, 0, 0, 0, 1);
        chk("add_lock_rel", int'(lock_req), 0);
        chk("add_busy", int'(busy), 0);
        chk("add_ack_cycles", ack_cycles, 3);
        chk("add_accepted", accepted, 3);
        $display("amoadd: acks=%0d accepted=%0d", ack_cycles, accepted);

        // amoswap with a 3-cycle stall in LD
        ack_cycles = 0; accepted = 0;
        cyc(1, 5'b00001, 0, 0, 0, 0);
        cyc(1, 5'b00001, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 5'b00001, 1, 0, 0, 0);
        cyc(1, 5'b00001, 0, 0, 0, 0);
        cyc(1, 5'b00001, 0, 0, 0, 0);
        chk("swap_drain_ack", int'(amo_ack), 0);
        cyc(0, 5'b00001, 0, 0, 0, 1);
        chk("swap_ack_cycles", ack_cycles, 5);
        chk("swap_accepted", accepted, 2);
        chk("swap_busy", int'(busy), 0);
        $display("amoswap: acks=%0d accepted=%0d", ack_cycles, accepted);

        // amoxor flushed in OP, then restarted
        cyc(1, 5'b00100, 0, 0, 0, 0);
        cyc(1, 5'b00100, 0, 0, 1, 0);
        cyc(1, 5'b00100, 0, 0, 0, 0);
        cyc(1, 5'b00100, 0, 1, 0, 0);
        chk("xor_flush_busy", int'(busy), 0);
        chk("xor_flush_lock", int'(lock_req), 0);
        cyc(1, 5'b00100, 0, 0, 0, 0);
        chk("xor_restart_busy", int'(busy), 1);
        chk("xor_restart_ack", int'(amo_ack), 0);
        cyc(1, 5'b00100, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 5'b00100, 0, 0, 0, 0);
        cyc(0, 5'b00100, 0, 1, 0, 1);
        chk("xor_done_busy", int'(busy), 0);
        $display("amoxor: flush in OP then restart");

        // amoand: store accepted together with flush, then drain timeout
        cyc(1, 5'b01100, 0, 0, 0, 0);
        cyc(1, 5'b01100, 0, 0, 1, 0);
        cyc(1, 5'b01100, 0, 0, 0, 0);
        cyc(1, 5'b01100, 0, 0, 0, 0);
        cyc(1, 5'b01100, 0, 1, 0, 0);
        chk("and_drain_busy", int'(busy), 1);
        first_err = 0; err_hits = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 5'b01100, 0, 0, 0, 0);
            if (amo_err === 1'b1) begin
                err_hits++;
                if (first_err == 0) first_err = k;
            end
        end
        chk("to_err_cycle", first_err, 8);
        chk("to_err_width", err_hits, 1);
        chk("to_lock_rel", int'(lock_req), 0);
        $display("timeout: amo_err at drain cycle %0d, pulses=%0d", first_err, err_hits);

        // Async reset in the middle of OP
        cyc(1, 5'b01000, 0, 0, 0, 0);
        cyc(1, 5'b01000, 0, 0, 1, 0);
        cyc(1, 5'b01000, 0, 0, 0, 0);
        chk("or_op_ack", int'(amo_ack), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_lock", int'(lock_req), 0);
        chk("arst_ack", int'(amo_ack), 0);
        chk("arst_busy", int'(busy), 0);
        amo_req = 1'b0; lock_gnt = 1'b0;
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_idle_busy", int'(busy), 0);
        chk("arst_idle_lock", int'(lock_req), 0);
        $display("async reset mid-OP");

        // Unsupported funct5 (amomin) held for 10 cycles
        ack_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 5'b10000, 0, 0, 1, 0);
            chk("min_lock", int'(lock_req), 0);
        end
        chk("min_ack_cycles", ack_cycles, 0);
        cyc(0, 5'b00000, 0, 0, 0, 0);
        $display("amomin: ignored for 10 cycles");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
